mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the MIPS pipeline. It takes a byte/half/word access from EX/MEM and drives a word-wide memory port with a valid/ready request handshake. Stores are narrowed and lane-placed with byte enables. Loads are extracted from the returned word and sign- or zero-extended to 32 bits.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/mem_lsu_if.sv | 40 ++++
 rtl/load_aligner.sv | 31 +++
 rtl/mem_lsu.sv | 97 +++++++++
 tb/tb_mem_lsu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NLANE = XLEN / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_R   = 3'd2,
        RESP     = 3'd3,
        ERR_RESP = 3'd4
    } lsu_state_e;

    // Request fields kept for the lifetime of one access
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sext;
        logic [1:0] lane;
    } lsu_ctl_t;

    // Size 11 is illegal; halves need an even address, words a 4-aligned one
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline request, memory port and response signals of the load/store unit.
interface mem_lsu_if;
    import lsu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_sext;
    logic [XLEN-1:0]     req_addr;
    logic [XLEN-1:0]     req_wdata;

    logic                mem_valid;
    logic                mem_ready;
    logic                mem_we;
    logic [NLANE-1:0]    mem_be;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;

    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/load_aligner.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module load_aligner
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            sext,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one byte/half/word access at a time over a valid/ready word port.
module mem_lsu
    import lsu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  bus
);

    lsu_state_e       state;
    lsu_state_e       state_nxt;
    lsu_ctl_t         ctl;
    logic             accept_c;
    logic             bad_c;
    logic [XLEN-1:0]  st_wdata_c;
    logic [NLANE-1:0] st_be_c;
    logic [XLEN-1:0]  ld_data_c;

    assign accept_c = bus.req_valid && (state == IDLE);
    assign bad_c    = is_misaligned(bus.req_size, bus.req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept_c) state_nxt = bad_c ? ERR_RESP : REQ;
            REQ:      if (bus.mem_ready) state_nxt = ctl.we ? RESP : WAIT_R;
            WAIT_R:   if (bus.mem_rvalid) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            ERR_RESP: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake and response strobes are pure state decodes
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.mem_valid = (state == REQ);
        bus.rsp_valid = (state == RESP) || (state == ERR_RESP);
        bus.rsp_err   = (state == ERR_RESP);
    end

    // Store data is replicated across lanes so the memory just honours mem_be
    always_comb begin
        case (bus.req_size)
            SZ_BYTE: begin
                st_wdata_c = {4{bus.req_wdata[7:0]}};
                st_be_c    = 4'b0001 << bus.req_addr[1:0];
            end
            SZ_HALF: begin
                st_wdata_c = {2{bus.req_wdata[15:0]}};
                st_be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_c = bus.req_wdata;
                st_be_c    = 4'b1111;
            end
        endcase
        if (!bus.req_we) st_be_c = 4'b1111;
    end

    load_aligner u_load_aligner (
        .rdata (bus.mem_rdata),
        .lane  (ctl.lane),
        .size  (ctl.size),
        .sext  (ctl.sext),
        .data  (ld_data_c)
    );

    // Memory-side fields are frozen at accept, which keeps them stable through stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            if (accept_c) begin
                ctl           <= '{we: bus.req_we, size: bus.req_size,
                                   sext: bus.req_sext, lane: bus.req_addr[1:0]};
                bus.mem_we    <= bus.req_we;
                bus.mem_be    <= st_be_c;
                bus.mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                bus.mem_wdata <= st_wdata_c;
                bus.rsp_rdata <= '0;
            end
            if ((state == WAIT_R) && bus.mem_rvalid) bus.rsp_rdata <= ld_data_c;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus random accesses against an arithmetic reference model.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
               (size == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sext);
        logic [31:0] s;
        logic [31:0] v;
        s = rdata >> (8 * (addr % 4));
        case (size)
            2'd0: begin
                v = s & 32'h0000_00FF;
                if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = s & 32'h0000_FFFF;
                if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (!we) return 4'hF;
        case (size)
            2'd0:    return 4'(32'd1 << (addr % 4));
            2'd1:    return 4'(32'd3 << (addr % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    return (wdata & 32'h0000_00FF) * 32'h0101_0101;
            2'd1:    return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_size  = 2'($urandom_range(0, 3));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Runs one access from an idle negedge to the idle negedge after the response
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int stall, input int dly);
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        check({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
        drive_req(we, size, sext, addr, wdata);
        if (ref_bad(size, addr)) begin
            check({tag, ".err_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, ".err_rsp_err"}, 32'(bus.rsp_err), 32'd1);
            check({tag, ".err_rsp_rdata"}, bus.rsp_rdata, 32'd0);
            check({tag, ".err_mem_valid"}, 32'(bus.mem_valid), 32'd0);
            @(negedge clk);
            check({tag, ".err_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
            check({tag, ".err_mem_valid2"}, 32'(bus.mem_valid), 32'd0);
            return;
        end
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd1);
        check({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
        check({tag, ".mem_be"}, 32'(bus.mem_be), 32'(ref_be(we, size, addr)));
        check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
        if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, ref_wdata(size, wdata));
        check({tag, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({tag, ".stall_valid"}, 32'(bus.mem_valid), 32'd1);
            check({tag, ".stall_addr"}, bus.mem_addr, exp_addr);
            if (we) check({tag, ".stall_wdata"}, bus.mem_wdata, ref_wdata(size, wdata));
            check({tag, ".stall_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, ".stall_rsp"}, 32'(bus.rsp_valid), 32'd0);
        end
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check({tag, ".mem_valid_drop"}, 32'(bus.mem_valid), 32'd0);
        if (!we) begin
            for (int i = 0; i < dly; i++) begin
                check({tag, ".wait_rsp"}, 32'(bus.rsp_valid), 32'd0);
                bus.mem_rdata = $urandom;
                @(negedge clk);
            end
            check({tag, ".wait_rsp_last"}, 32'(bus.rsp_valid), 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, we ? 32'd0 : ref_load(rdata, addr, size, sext));
        check({tag, ".req_ready_rsp"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, ".pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, ".mem_be"}, 32'(bus.mem_be), 32'd0);
        check({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_sext   = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        do_access("st_byte", 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, '0, 0, 0);
        do_access("ld_half_sext", 1'b0, 2'd1, 1'b1, 32'h0000_2002, '0, 32'h8001_1234, 0, 0);
        do_access("ld_half_zext", 1'b0, 2'd1, 1'b0, 32'h0000_2002, '0, 32'h8001_1234, 0, 0);
        do_access("ld_byte_zext", 1'b0, 2'd0, 1'b0, 32'h0000_0011, '0, 32'h0000_F000, 0, 0);
        do_access("ld_word_misal", 1'b0, 2'd2, 1'b0, 32'h0000_3002, '0, '0, 0, 0);
        do_access("st_size_illegal", 1'b1, 2'd3, 1'b0, 32'h0000_4000, 32'h1234_5678, '0, 0, 0);
        do_access("st_word_stall", 1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, '0, 3, 0);
        do_access("ld_byte_sext_slow", 1'b0, 2'd0, 1'b1, 32'h0000_6003, '0, 32'h9A00_0000, 2, 3);

        // Reset while waiting for read data; a stale rvalid must then be ignored
        check(".rst_mid_idle", 32'(bus.req_ready), 32'd1);
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0040, '0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_mid");
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("rst_stale.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_stale.req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("rst_stale.rsp_valid2", 32'(bus.rsp_valid), 32'd0);
        do_access("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h0000_0040, '0, 32'h1357_9BDF, 0, 0);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
                if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
            end
            do_access($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz,
                      1'($urandom_range(0, 1)), a, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
